// File: rtl/io_port_bank_pkg.sv
// Shared definitions for the IO port bank: address-map offsets, STATUS bit
// positions and the address-decode result type.
package io_pkg;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_OUT,
        SEL_IN,
        SEL_STATUS,
        SEL_TIMER
    } sel_e;

    function automatic int ofs_status(input int n_out, input int n_in);
        return n_out + n_in;
    endfunction

    function automatic int ofs_timer(input int n_out, input int n_in);
        return n_out + n_in + 1;
    endfunction

    function automatic int status_timer_wrap(input int data_width);
        return data_width - 1;
    endfunction

endpackage

// File: rtl/io_port_bank_sync_edge.sv
// One input port: SYNC_STAGES-deep synchroniser chain followed by a
// change detector comparing the synced value with its previous sample.
module io_sync_edge #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_async,
    output logic [DATA_WIDTH-1:0] o_sync,
    output logic                  o_change
);

    logic [DATA_WIDTH-1:0] chain_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] prev_q;

    // NOTE: every stage resets to 0 together with prev_q, so an input held
    // low through reset release never produces a change pulse.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) chain_q[s] <= '0;
            prev_q <= '0;
        end else begin
            chain_q[0] <= i_async;
            for (int s = 1; s < SYNC_STAGES; s++) chain_q[s] <= chain_q[s-1];
            prev_q <= chain_q[SYNC_STAGES-1];
        end
    end

    assign o_sync   = chain_q[SYNC_STAGES-1];
    assign o_change = (o_sync != prev_q);

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped bank of output registers, synchronised inputs, a read-clear
// change/wrap STATUS register and a prescaled TIMER on the shared IO bus.
module io_port_bank
    import io_pkg::*;
#(
    parameter int                  DATA_WIDTH     = 8,
    parameter int                  ADDR_WIDTH     = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 8'h00,
    parameter int                  N_OUT          = 2,
    parameter int                  N_IN           = 2,
    parameter int                  SYNC_STAGES    = 2,
    parameter int                  TIMER_PRESCALE = 1000
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [DATA_WIDTH-1:0]       i_bus,
    output logic [DATA_WIDTH-1:0]       o_bus,
    output logic                        o_busNOE,
    input  logic                        i_ioNCE,
    input  logic [ADDR_WIDTH-1:0]       i_ioAddress,
    input  logic                        i_ioNOE,
    input  logic                        i_ioNWE,
    input  logic [N_IN*DATA_WIDTH-1:0]  i_inputs,
    output logic [N_OUT*DATA_WIDTH-1:0] o_outputs
);

    localparam int OFS_STATUS        = ofs_status(N_OUT, N_IN);
    localparam int OFS_TIMER         = ofs_timer(N_OUT, N_IN);
    localparam int STATUS_TIMER_WRAP = status_timer_wrap(DATA_WIDTH);
    localparam int PW                = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TIMER_PRESCALE - 1);

    logic [ADDR_WIDTH-1:0] ofs;
    sel_e                  sel_kind;
    logic                  sel, wr_en, rd_en;

    assign ofs = i_ioAddress - BASE_ADDR;

    // The explicit lower-bound test keeps addresses below BASE_ADDR from
    // aliasing into the window through the wrapped subtraction.
    always_comb begin
        sel_kind = SEL_NONE;
        if (!i_ioNCE && (i_ioAddress >= BASE_ADDR)) begin
            if (ofs < ADDR_WIDTH'(N_OUT))                sel_kind = SEL_OUT;
            else if (ofs < ADDR_WIDTH'(OFS_STATUS))      sel_kind = SEL_IN;
            else if (ofs == ADDR_WIDTH'(OFS_STATUS))     sel_kind = SEL_STATUS;
            else if (ofs == ADDR_WIDTH'(OFS_TIMER))      sel_kind = SEL_TIMER;
        end
    end

    assign sel   = (sel_kind != SEL_NONE);
    assign wr_en = sel && !i_ioNWE;
    assign rd_en = sel && !i_ioNOE && i_ioNWE;

    logic [DATA_WIDTH-1:0] in_sync [N_IN];
    logic [N_IN-1:0]       in_change;

    for (genvar k = 0; k < N_IN; k++) begin : g_in
        io_sync_edge #(
            .DATA_WIDTH  (DATA_WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_async  (i_inputs[k*DATA_WIDTH +: DATA_WIDTH]),
            .o_sync   (in_sync[k]),
            .o_change (in_change[k])
        );
    end

    logic [DATA_WIDTH-1:0] out_q [N_OUT];
    logic [DATA_WIDTH-1:0] out_d [N_OUT];

    // NOTE: each next-state signal takes its hold value first, so no path
    // through the comb block leaves it unassigned and no latch is inferred.
    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            out_d[k] = out_q[k];
            if (wr_en && (sel_kind == SEL_OUT) && (ofs == ADDR_WIDTH'(k))) out_d[k] = i_bus;
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        assign o_outputs[k*DATA_WIDTH +: DATA_WIDTH] = out_q[k];
    end

    logic [PW-1:0]         presc_q, presc_d;
    logic [DATA_WIDTH-1:0] timer_q, timer_d;
    logic                  tick, wrap_evt, timer_wr;

    assign tick     = (presc_q == PRESC_LAST);
    assign timer_wr = wr_en && (sel_kind == SEL_TIMER);

    always_comb begin
        presc_d  = tick ? '0 : presc_q + 1'b1;
        timer_d  = tick ? timer_q + 1'b1 : timer_q;
        wrap_evt = tick && (timer_q == '1);
        if (timer_wr) begin
            presc_d  = '0;
            timer_d  = i_bus;
            wrap_evt = 1'b0;
        end
    end

    logic [DATA_WIDTH-1:0] status_q, status_d, status_set;
    logic                  status_clr;

    assign status_clr = rd_en && (sel_kind == SEL_STATUS);

    // Set events are OR-ed in after the clear, so a coincident event survives.
    always_comb begin
        status_set                    = '0;
        status_set[N_IN-1:0]          = in_change;
        status_set[STATUS_TIMER_WRAP] = wrap_evt;
        status_d = (status_clr ? '0 : status_q) | status_set;
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge value of its neighbours.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
            presc_q  <= '0;
            timer_q  <= '0;
            status_q <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) out_q[k] <= out_d[k];
            presc_q  <= presc_d;
            timer_q  <= timer_d;
            status_q <= status_d;
        end
    end

    logic [DATA_WIDTH-1:0] rd_data;

    always_comb begin
        rd_data = '0;
        case (sel_kind)
            SEL_OUT: begin
                for (int k = 0; k < N_OUT; k++)
                    if (ofs == ADDR_WIDTH'(k)) rd_data = out_q[k];
            end
            SEL_IN: begin
                for (int k = 0; k < N_IN; k++)
                    if (ofs == ADDR_WIDTH'(N_OUT + k)) rd_data = in_sync[k];
            end
            SEL_STATUS: rd_data = status_q;
            SEL_TIMER:  rd_data = timer_q;
            default:    rd_data = '0;
        endcase
    end

    assign o_busNOE = ~rd_en;
    assign o_bus    = rd_en ? rd_data : '0;

endmodule

// File: tb/tb_io_port_bank.sv
// Directed self-checking bench for io_port_bank with N_OUT=2, N_IN=2,
// SYNC_STAGES=2 and TIMER_PRESCALE=4; expected values are hand-derived.
module tb_io_port_bank;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] bus_in;
    logic [DW-1:0] bus_out;
    logic          bus_noe;
    logic          nce;
    logic [AW-1:0] addr;
    logic          noe;
    logic          nwe;
    logic [2*DW-1:0] inputs;
    logic [2*DW-1:0] outputs;

    int checks = 0;
    int errors = 0;

    io_port_bank #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .BASE_ADDR      (8'h00),
        .N_OUT          (2),
        .N_IN           (2),
        .SYNC_STAGES    (2),
        .TIMER_PRESCALE (4)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_bus       (bus_in),
        .o_bus       (bus_out),
        .o_busNOE    (bus_noe),
        .i_ioNCE     (nce),
        .i_ioAddress (addr),
        .i_ioNOE     (noe),
        .i_ioNWE     (nwe),
        .i_inputs    (inputs),
        .o_outputs   (outputs)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        nce    = 1'b1;
        noe    = 1'b1;
        nwe    = 1'b1;
        addr   = '0;
        bus_in = '0;
    endtask

    // Combinational access inside one clock phase; strobes dropped before the edge.
    task automatic peek(input logic [AW-1:0] a, input logic we_n,
                        input logic [DW-1:0] exp_bus, input logic exp_noe, input string tag);
        nce  = 1'b0;
        addr = a;
        noe  = 1'b0;
        nwe  = we_n;
        #1;
        check({tag, "_bus"}, 32'(bus_out), 32'(exp_bus));
        check({tag, "_noe"}, 32'(bus_noe), 32'(exp_noe));
        idle();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        nce    = 1'b0;
        addr   = a;
        bus_in = d;
        noe    = 1'b1;
        nwe    = 1'b0;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        @(negedge clk);
        nce  = 1'b0;
        addr = a;
        noe  = 1'b0;
        nwe  = 1'b1;
        #1;
        check({tag, "_bus"}, 32'(bus_out), 32'(exp));
        check({tag, "_noe"}, 32'(bus_noe), 32'd0);
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        inputs = '0;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state sweep within one low phase
        for (int a = 0; a < 6; a++) peek(AW'(a), 1'b1, 8'h00, 1'b0, $sformatf("rst_rd%0d", a));
        peek(8'd6, 1'b1, 8'h00, 1'b1, "rst_rd6_unsel");
        peek(8'hFF, 1'b1, 8'h00, 1'b1, "rst_rdFF_unsel");
        check("rst_outputs", 32'(outputs), 32'h0);

        // Output register write/read, and write/read conflict
        wr(8'd1, 8'hA5);
        check("out1_pins", 32'(outputs), 32'hA500);
        rd(8'd1, 8'hA5, "out1_rd");
        peek(8'd1, 1'b0, 8'h00, 1'b1, "wr_wins");
        wr(8'd2, 8'h5A);
        rd(8'd2, 8'h00, "in0_ro");
        check("out_after_in_wr", 32'(outputs), 32'hA500);

        // Synchroniser latency and change detect
        @(negedge clk);
        inputs[7:0] = 8'h3C;
        @(posedge clk); #1;
        peek(8'd2, 1'b1, 8'h00, 1'b0, "in0_lat1");
        @(posedge clk); #1;
        peek(8'd2, 1'b1, 8'h3C, 1'b0, "in0_lat2");
        @(posedge clk); #1;
        rd(8'd4, 8'h01, "status_set");
        rd(8'd4, 8'h00, "status_clr");

        // Set event coincident with a clearing STATUS read
        @(negedge clk);
        inputs[15:8] = 8'h01;
        @(posedge clk);
        @(posedge clk); #1;
        rd(8'd4, 8'h00, "status_pre");
        rd(8'd4, 8'h02, "status_setwins");
        rd(8'd4, 8'h00, "status_clr2");

        // STATUS writes are ignored
        wr(8'd4, 8'hFF);
        rd(8'd4, 8'h00, "status_wr_ign");

        // Timer load, prescale and wrap
        wr(8'd5, 8'hFE);
        peek(8'd5, 1'b1, 8'hFE, 1'b0, "tmr_load");
        repeat (3) @(posedge clk);
        #1;
        peek(8'd5, 1'b1, 8'hFE, 1'b0, "tmr_3clk");
        @(posedge clk); #1;
        peek(8'd5, 1'b1, 8'hFF, 1'b0, "tmr_4clk");
        repeat (3) @(posedge clk);
        #1;
        peek(8'd5, 1'b1, 8'hFF, 1'b0, "tmr_7clk");
        @(posedge clk); #1;
        peek(8'd5, 1'b1, 8'h00, 1'b0, "tmr_8clk");
        rd(8'd4, 8'h80, "status_wrap");
        rd(8'd4, 8'h00, "status_wrap_clr");

        // Reset during a write
        @(negedge clk);
        inputs[7:0] = 8'h00;
        repeat (3) @(posedge clk);
        wr(8'd0, 8'h77);
        check("out0_pins", 32'(outputs), 32'hA577);
        wr(8'd5, 8'h33);
        @(negedge clk);
        nce    = 1'b0;
        addr   = 8'd0;
        bus_in = 8'hEE;
        noe    = 1'b1;
        nwe    = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_out", 32'(outputs), 32'h0);
        check("rst_mid_noe", 32'(bus_noe), 32'd1);
        noe  = 1'b0;
        nwe  = 1'b1;
        addr = 8'd5;
        #1;
        check("rst_mid_tmr", 32'(bus_out), 32'h0);
        check("rst_mid_rdnoe", 32'(bus_noe), 32'd0);
        addr = 8'd4;
        #1;
        check("rst_mid_status", 32'(bus_out), 32'h0);
        addr = 8'd0;
        noe  = 1'b1;
        nwe  = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("rel_no_edge", 32'(outputs), 32'h0);
        idle();
        @(posedge clk); #1;
        check("rel_after_edge", 32'(outputs), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_port_bank.md
Name: io_port_bank

Overview:
Parametrised successor of the single-port IO card. It is a memory-mapped bank of output registers, synchronised input ports, a change-detect status register and a prescaled timer.
- Sits on the shared tristate data bus behind the memory block's IO strobes (ioNCE/ioAddress/ioNOE/ioNWE).
- Drives its bus contribution with an active-low output enable, like every other bus source.
- Replaces the fixed output/switch IO block on larger boards with more channels and wider data.

Parameters:
DATA_WIDTH, 8, bus and register width
ADDR_WIDTH, 8, width of i_ioAddress
BASE_ADDR, 8'h00, first address of the bank window
N_OUT, 2, number of output registers (1..16)
N_IN, 2, number of input ports (1..DATA_WIDTH-1)
SYNC_STAGES, 2, synchroniser flops per input bit (>=2)
TIMER_PRESCALE, 1000, clocks per timer tick (>=1)

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_bus  in  DATA_WIDTH  shared bus value (write data)
o_bus  out  DATA_WIDTH  read data
o_busNOE  out  1  active-low bus drive enable
i_ioNCE  in  1  IO chip enable, active low
i_ioAddress  in  ADDR_WIDTH  IO address
i_ioNOE  in  1  read strobe, active low
i_ioNWE  in  1  write strobe, active low
i_inputs  in  N_IN*DATA_WIDTH  external async inputs, port k at [k*DW +: DW]
o_outputs  out  N_OUT*DATA_WIDTH  output registers, same packing

Behaviour:
- Address map, offset = i_ioAddress - BASE_ADDR:
  - 0..N_OUT-1: OUT[k], read/write.
  - N_OUT..N_OUT+N_IN-1: IN[k], synchronised, read-only; writes ignored.
  - S = N_OUT+N_IN: STATUS, read-clear.
  - S+1: TIMER, read/write.
  - Any other offset (including addresses below BASE_ADDR) is unselected.
- sel = ~i_ioNCE & address in window.
- Write: on rising i_clk when sel & ~i_ioNWE, the target register takes i_bus.
- Read is combinational:
  - o_busNOE = ~(sel & ~i_ioNOE & i_ioNWE).
  - o_bus = addressed register while driving, else all-zero.
  - When NWE and NOE are both low, the write wins and the bus is not driven.
- Synchroniser: each input bit passes through a SYNC_STAGES flop chain. IN[k] is the last stage, so latency is SYNC_STAGES clocks.
- Change detect: prev[k] holds the previous IN[k]. STATUS[k] is set when IN[k] != prev[k].
- Timer:
  - Prescaler counts 0..TIMER_PRESCALE-1 and wraps.
  - On wrap, TIMER increments modulo 2^DATA_WIDTH.
  - TIMER rolling from all-ones to 0 sets STATUS[DATA_WIDTH-1].
  - A write to TIMER loads i_bus and clears the prescaler; it does not set the wrap flag that cycle.
- STATUS read-clear: on rising i_clk with a read of STATUS (sel, ~NOE, NWE high), all STATUS bits clear. A set event in the same cycle wins, so that bit stays 1.
- STATUS bits N_IN..DATA_WIDTH-2 always read 0. Writes to STATUS are ignored.
- Reset (async, any time, including mid-access):
  - OUT, sync chains, prev, STATUS, TIMER and prescaler all go to 0.
  - o_busNOE follows its decode immediately (high unless a read is in progress).
  - After reset release, no spurious change flags for inputs held at 0.
- No handshake wait states: every access completes in the strobe cycle.

Decomposition:
- Shared package io_pkg:
  - offset constants as functions of N_OUT/N_IN (OFS_STATUS, OFS_TIMER);
  - STATUS bit index STATUS_TIMER_WRAP = DATA_WIDTH-1;
  - address-decode result enum (SEL_NONE, SEL_OUT, SEL_IN, SEL_STATUS, SEL_TIMER).
- One sub-module, io_sync_edge: per-port synchroniser chain plus change-detect, instantiated N_IN times. Its outputs are the synced value and a change pulse.
- Decode, register file, timer and read mux stay in io_port_bank.

Test Plan:
- Reset, then read every address (N_OUT=2, N_IN=2): all reads return 8'h00, o_busNOE=0 on in-window reads, o_busNOE=1 at offset 6.
- Write 8'hA5 to offset 1 → o_outputs[15:8]=8'hA5 next clock; read returns 8'hA5. Write to offset 2 → IN[0] unchanged.
- Drive i_inputs[7:0]=8'h3C → IN[0] reads 8'h3C after exactly 2 clocks. STATUS reads 8'h01, the read clears it, and a second read gives 8'h00.
- Toggle input 1 in the same cycle as a STATUS read → STATUS[1]=1 after the read (set wins).
- TIMER_PRESCALE=4, write TIMER=8'hFE → reads 8'hFF after 4 clocks and 8'h00 after 8 clocks; STATUS[7]=1.
- Assert i_reset mid-write (NWE low) → OUT/TIMER/STATUS 0 immediately; after release the write is not applied without a new clock edge.
